// File: rtl/i2c_bus_checker.sv
// Passive I2C bus checker: decodes START / repeated START / STOP, address and
// data bytes and ACK/NACK from the resolved SCL/SDA lines; flags sticky errors.
module i2c_bus_checker #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TIMEOUT_W      = 16,
    parameter int BCNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    input  logic              err_clear,
    output logic              bus_busy,
    output logic              start_p,
    output logic              rstart_p,
    output logic              stop_p,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_is_addr,
    output logic              ack_valid,
    output logic              nack,
    output logic [BCNT_W-1:0] byte_count,
    output logic              err_setup,
    output logic              err_idle_scl,
    output logic              err_frame,
    output logic              err_timeout
);

    localparam logic [1:0] ST_WAIT_FREE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_ACTIVE    = 2'd2;

    localparam int                   SETTLE_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_DONE = SETTLE_W'(SYNC_STAGES);
    localparam logic [TIMEOUT_W-1:0] TO_LIMIT    = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam bit                   TO_EN       = (TIMEOUT_CYCLES != 0);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_q, scl_d, sda_q, sda_d;
    logic                   scl_s, sda_s;
    logic [SETTLE_W-1:0]    settle_q, settle_d;

    logic [1:0]           state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           pre_cnt_q, pre_cnt_d;
    logic                 rise_pend_q, rise_pend_d;
    logic [6:0]           shift_q, shift_d;
    logic                 addr_next_q, addr_next_d;
    logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;

    logic              bus_busy_q, bus_busy_d;
    logic              start_p_q, start_p_d;
    logic              rstart_p_q, rstart_p_d;
    logic              stop_p_q, stop_p_d;
    logic              byte_valid_q, byte_valid_d;
    logic [7:0]        byte_data_q, byte_data_d;
    logic              byte_is_addr_q, byte_is_addr_d;
    logic              ack_valid_q, ack_valid_d;
    logic              nack_q, nack_d;
    logic [BCNT_W-1:0] byte_count_q, byte_count_d;
    logic              err_setup_q, err_setup_d;
    logic              err_idle_scl_q, err_idle_scl_d;
    logic              err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d;

    logic       set_setup, set_idle_scl, set_frame, set_timeout;
    logic       scl_rise, scl_fall, both_chg, start_det, stop_det;
    logic [3:0] frame_cnt;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    assign scl_rise  = ~scl_q & scl_s;
    assign scl_fall  = scl_q & ~scl_s;
    assign both_chg  = (scl_q ^ scl_s) & (sda_q ^ sda_s);
    assign start_det = ~both_chg & scl_q & scl_s & sda_q & ~sda_s;
    assign stop_det  = ~both_chg & scl_q & scl_s & ~sda_q & sda_s;

    // START/STOP always follow the SCL rise that opened the high phase; that
    // rise already bumped bit_cnt, so framing is judged on the count before it.
    assign frame_cnt = rise_pend_q ? pre_cnt_q : bit_cnt_q;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_d      = scl_s;
        sda_d      = sda_s;
        // Chain resets to idle-high; wait until real pin samples reach scl_s/sda_s.
        settle_d   = (settle_q == SETTLE_DONE) ? settle_q : settle_q + SETTLE_W'(1);
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        pre_cnt_d      = pre_cnt_q;
        rise_pend_d    = rise_pend_q;
        shift_d        = shift_q;
        addr_next_d    = addr_next_q;
        to_cnt_d       = '0;
        bus_busy_d     = bus_busy_q;
        start_p_d      = 1'b0;
        rstart_p_d     = 1'b0;
        stop_p_d       = 1'b0;
        byte_valid_d   = 1'b0;
        ack_valid_d    = 1'b0;
        byte_data_d    = byte_data_q;
        byte_is_addr_d = byte_is_addr_q;
        nack_d         = nack_q;
        byte_count_d   = byte_count_q;
        set_setup      = 1'b0;
        set_idle_scl   = 1'b0;
        set_frame      = 1'b0;
        set_timeout    = 1'b0;

        if (scl_rise) begin
            rise_pend_d = 1'b1;
            pre_cnt_d   = bit_cnt_q;
        end else if (scl_fall) begin
            rise_pend_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_FREE: begin
                if ((settle_q == SETTLE_DONE) && scl_s && sda_s) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                set_setup    = both_chg;
                set_idle_scl = scl_fall;
                if (start_det) begin
                    state_d      = ST_ACTIVE;
                    start_p_d    = 1'b1;
                    bus_busy_d   = 1'b1;
                    bit_cnt_d    = '0;
                    byte_count_d = '0;
                    addr_next_d  = 1'b1;
                    rise_pend_d  = 1'b0;
                end
            end
            ST_ACTIVE: begin
                set_setup = both_chg;
                if (!scl_s) begin
                    to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TIMEOUT_W'(1);
                end
                if (start_det) begin
                    rstart_p_d   = 1'b1;
                    set_frame    = (frame_cnt != 4'd0);
                    bit_cnt_d    = '0;
                    byte_count_d = '0;
                    addr_next_d  = 1'b1;
                    rise_pend_d  = 1'b0;
                end else if (stop_det) begin
                    stop_p_d    = 1'b1;
                    set_frame   = (frame_cnt != 4'd0);
                    bus_busy_d  = 1'b0;
                    state_d     = ST_IDLE;
                    rise_pend_d = 1'b0;
                end else if (TO_EN && (to_cnt_d == TO_LIMIT)) begin
                    set_timeout = 1'b1;
                    bus_busy_d  = 1'b0;
                    state_d     = ST_WAIT_FREE;
                end else if (scl_rise) begin
                    if (bit_cnt_q == 4'd8) begin
                        ack_valid_d = 1'b1;
                        nack_d      = sda_s;
                        bit_cnt_d   = '0;
                    end else begin
                        shift_d   = {shift_q[5:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            byte_valid_d   = 1'b1;
                            byte_data_d    = {shift_q, sda_s};
                            byte_is_addr_d = addr_next_q;
                            addr_next_d    = 1'b0;
                            if (byte_count_q != '1) begin
                                byte_count_d = byte_count_q + BCNT_W'(1);
                            end
                        end
                    end
                end
            end
            default: state_d = ST_WAIT_FREE;
        endcase

        // A new violation wins over a simultaneous clear.
        err_setup_d    = set_setup    | (err_setup_q    & ~err_clear);
        err_idle_scl_d = set_idle_scl | (err_idle_scl_q & ~err_clear);
        err_frame_d    = set_frame    | (err_frame_q    & ~err_clear);
        err_timeout_d  = set_timeout  | (err_timeout_q  & ~err_clear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q     <= '1;
            sda_sync_q     <= '1;
            scl_q          <= 1'b1;
            sda_q          <= 1'b1;
            settle_q       <= '0;
            state_q        <= ST_WAIT_FREE;
            bit_cnt_q      <= '0;
            pre_cnt_q      <= '0;
            rise_pend_q    <= 1'b0;
            shift_q        <= '0;
            addr_next_q    <= 1'b0;
            to_cnt_q       <= '0;
            bus_busy_q     <= 1'b0;
            start_p_q      <= 1'b0;
            rstart_p_q     <= 1'b0;
            stop_p_q       <= 1'b0;
            byte_valid_q   <= 1'b0;
            byte_data_q    <= '0;
            byte_is_addr_q <= 1'b0;
            ack_valid_q    <= 1'b0;
            nack_q         <= 1'b0;
            byte_count_q   <= '0;
            err_setup_q    <= 1'b0;
            err_idle_scl_q <= 1'b0;
            err_frame_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            scl_sync_q     <= scl_sync_d;
            sda_sync_q     <= sda_sync_d;
            scl_q          <= scl_d;
            sda_q          <= sda_d;
            settle_q       <= settle_d;
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            pre_cnt_q      <= pre_cnt_d;
            rise_pend_q    <= rise_pend_d;
            shift_q        <= shift_d;
            addr_next_q    <= addr_next_d;
            to_cnt_q       <= to_cnt_d;
            bus_busy_q     <= bus_busy_d;
            start_p_q      <= start_p_d;
            rstart_p_q     <= rstart_p_d;
            stop_p_q       <= stop_p_d;
            byte_valid_q   <= byte_valid_d;
            byte_data_q    <= byte_data_d;
            byte_is_addr_q <= byte_is_addr_d;
            ack_valid_q    <= ack_valid_d;
            nack_q         <= nack_d;
            byte_count_q   <= byte_count_d;
            err_setup_q    <= err_setup_d;
            err_idle_scl_q <= err_idle_scl_d;
            err_frame_q    <= err_frame_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus_busy     = bus_busy_q;
    assign start_p      = start_p_q;
    assign rstart_p     = rstart_p_q;
    assign stop_p       = stop_p_q;
    assign byte_valid   = byte_valid_q;
    assign byte_data    = byte_data_q;
    assign byte_is_addr = byte_is_addr_q;
    assign ack_valid    = ack_valid_q;
    assign nack         = nack_q;
    assign byte_count   = byte_count_q;
    assign err_setup    = err_setup_q;
    assign err_idle_scl = err_idle_scl_q;
    assign err_frame    = err_frame_q;
    assign err_timeout  = err_timeout_q;

endmodule
